cache_miss_ctrl: RTL and testbench

- Central miss sequencer and main-memory arbiter for the 5-stage pipeline.
- Produces the global pipeline enable `hit`. Every inter-stage register latches only when `hit`=1.
- Arbitrates instruction-cache and data-cache misses onto a single word-wide main-memory port.
- Sequences the dirty-victim writeback and the line refill, one word per memory acknowledge.

---
 rtl/cache_miss_ctrl.sv | 126 ++++++++++++
 tb/tb_cache_miss_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer and main-memory arbiter for the 5-stage pipeline.
// Grants I- and D-cache misses onto one word-wide memory port (D first),
// runs the optional dirty-victim writeback, then the line refill, and
// produces the global pipeline enable 'hit'.
//
// Memory handshake: mem_req stays high for every beat of a burst and the
// beat address/direction are held stable until mem_ack pulses for one cycle.
// A beat completes exactly on the posedge where mem_req=1 and mem_ack=1.
// mem_ack outside a burst is ignored.
module cache_miss_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imiss,
    input  logic [31:0]      imiss_addr,
    input  logic             dmiss,
    input  logic [31:0]      dmiss_addr,
    input  logic             dvictim_dirty,
    input  logic [31:0]      dvictim_addr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    output logic [IDX_W-1:0] word_idx,
    output logic             refill_sel,
    output logic             refill_valid,
    output logic             refill_done,
    output logic             hit,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Clears the word and byte offset bits so a latched address is a line base.
    localparam logic [31:0]      BASE_MASK = ~((32'(LINE_WORDS) << 2) - 32'd1);
    localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(LINE_WORDS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [31:0]      line_base_q, line_base_d;
    logic [31:0]      victim_base_q, victim_base_d;
    logic [31:0]      beat_base;

    // Next-state logic: arbitration in IDLE, beat counting in WB/FILL.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        line_base_d   = line_base_q;
        victim_base_d = victim_base_q;
        case (state_q)
            S_IDLE: begin
                // D has priority: its miss belongs to the older instruction.
                if (dmiss) begin
                    sel_d       = 1'b1;
                    cnt_d       = '0;
                    line_base_d = dmiss_addr & BASE_MASK;
                    if (dvictim_dirty) begin
                        victim_base_d = dvictim_addr & BASE_MASK;
                        state_d       = S_WB;
                    end else begin
                        state_d = S_FILL;
                    end
                end else if (imiss) begin
                    sel_d       = 1'b0;
                    cnt_d       = '0;
                    line_base_d = imiss_addr & BASE_MASK;
                    state_d     = S_FILL;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any burst in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sel_q         <= 1'b0;
            line_base_q   <= '0;
            victim_base_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            line_base_q   <= line_base_d;
            victim_base_q <= victim_base_d;
        end
    end

    // Output decode; hit drops in the same cycle a miss appears.
    always_comb begin
        beat_base    = (state_q == S_WB) ? victim_base_q : line_base_q;
        mem_req      = (state_q == S_WB) || (state_q == S_FILL);
        mem_we       = (state_q == S_WB);
        mem_addr     = beat_base + {{(30 - IDX_W){1'b0}}, cnt_q, 2'b00};
        word_idx     = cnt_q;
        refill_sel   = sel_q;
        refill_valid = (state_q == S_FILL) && mem_ack;
        refill_done  = (state_q == S_DONE);
        hit          = rst_n && (state_q == S_IDLE) && !imiss && !dmiss;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed scenarios with literal expectations,
// then randomized misses/acks checked every cycle against a transaction
// model that expands each grant into a queue of expected memory beats.
module tb_cache_miss_ctrl;

  localparam int LW = 4;
  localparam logic [31:0] MASK = ~32'(LW * 4 - 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imiss, dmiss, dvictim_dirty, mem_ack;
  logic [31:0] imiss_addr, dmiss_addr, dvictim_addr;
  logic        mem_req, mem_we, refill_sel, refill_valid, refill_done, hit;
  logic [31:0] mem_addr;
  logic [1:0]  word_idx;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  cache_miss_ctrl #(.LINE_WORDS(LW), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imiss(imiss), .imiss_addr(imiss_addr),
    .dmiss(dmiss), .dmiss_addr(dmiss_addr),
    .dvictim_dirty(dvictim_dirty), .dvictim_addr(dvictim_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .word_idx(word_idx), .refill_sel(refill_sel), .refill_valid(refill_valid),
    .refill_done(refill_done), .hit(hit), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- transaction model ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  idx;
  } beat_t;

  beat_t beats[$];
  bit m_busy = 0;   // beats outstanding
  bit m_done = 0;   // completion-pulse cycle
  bit m_sel  = 0;   // owner of the last grant
  bit clr_i  = 0;   // owner drops its miss at the next drive point
  bit clr_d  = 0;

  task automatic model_reset();
    beats.delete();
    m_busy = 0; m_done = 0; m_sel = 0; clr_i = 0; clr_d = 0;
  endtask

  task automatic push_line(input bit we, input logic [31:0] addr);
    beat_t b;
    for (int i = 0; i < LW; i++) begin
      b.we = we;
      b.addr = (addr & MASK) + 32'(4 * i);
      b.idx = 2'(i);
      beats.push_back(b);
    end
  endtask

  task automatic model_step();
    if (m_done) begin
      m_done = 0;
      if (m_sel) clr_d = 1; else clr_i = 1;
    end else if (m_busy) begin
      if (mem_ack) begin
        beats.delete(0);
        if (beats.size() == 0) begin m_busy = 0; m_done = 1; end
      end
    end else if (dmiss) begin
      m_sel = 1;
      if (dvictim_dirty) push_line(1'b1, dvictim_addr);
      push_line(1'b0, dmiss_addr);
      m_busy = 1;
    end else if (imiss) begin
      m_sel = 0;
      push_line(1'b0, imiss_addr);
      m_busy = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    #1;
    check("hit", 32'(hit), 32'(rst_n && !m_busy && !m_done && !imiss && !dmiss));
    check("mem_req", 32'(mem_req), 32'(m_busy));
    check("refill_done", 32'(refill_done), 32'(m_done));
    check("refill_sel", 32'(refill_sel), 32'(m_sel));
    check("refill_valid", 32'(refill_valid), 32'(m_busy && mem_ack && !beats[0].we));
    check("word_idx", 32'(word_idx), m_busy ? 32'(beats[0].idx) : 32'd0);
    if (m_busy) begin
      check("mem_we", 32'(mem_we), 32'(beats[0].we));
      check("mem_addr", mem_addr, beats[0].addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (clr_i) begin imiss = 0; clr_i = 0; end
    if (clr_d) begin dmiss = 0; clr_d = 0; end
  endtask

  task automatic run_random(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      imiss_addr    = $urandom;
      dmiss_addr    = $urandom;
      dvictim_addr  = $urandom;
      dvictim_dirty = 1'($urandom_range(0, 1));
      mem_ack       = ($urandom_range(0, 2) != 0);
      if (!imiss && !((m_busy || m_done) && !m_sel) && $urandom_range(0, 9) == 0) imiss = 1;
      if (!dmiss && !((m_busy || m_done) && m_sel) && $urandom_range(0, 9) == 0) dmiss = 1;
      // occasional flush of the owner's miss mid-transaction
      if (m_busy && $urandom_range(0, 40) == 0) begin
        if (m_sel) dmiss = 0; else imiss = 0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; imiss = 0; dmiss = 0; dvictim_dirty = 0; mem_ack = 0;
    imiss_addr = '0; dmiss_addr = '0; dvictim_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_hit", 32'(hit), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_idx", 32'(word_idx), 32'd0);

    // I refill, ack every cycle
    tick();
    imiss = 1; imiss_addr = 32'h0040_0014; mem_ack = 1;
    #1 check("i_hit_drop", 32'(hit), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("i_addr", mem_addr, 32'h0040_0010 + 32'(4 * k));
      check("i_we", 32'(mem_we), 32'd0);
      check("i_valid", 32'(refill_valid), 32'd1);
    end
    tick(); #1;
    check("i_done", 32'(refill_done), 32'd1);
    mem_ack = 0;
    tick(); #1;
    check("i_hit_back", 32'(hit), 32'd1);

    // D miss with dirty victim
    tick();
    dmiss = 1; dmiss_addr = 32'h1000_0108; dvictim_dirty = 1;
    dvictim_addr = 32'h1000_0020; mem_ack = 1;
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      check("d_addr", mem_addr, (k < 4) ? 32'h1000_0020 + 32'(4 * k) : 32'h1000_0100 + 32'(4 * (k - 4)));
      check("d_we", 32'(mem_we), (k < 4) ? 32'd1 : 32'd0);
      check("d_sel", 32'(refill_sel), 32'd1);
    end
    tick(); #1;
    check("d_done", 32'(refill_done), 32'd1);
    mem_ack = 0; dvictim_dirty = 0;
    tick();

    // simultaneous I and D: D first, no hit gap
    tick();
    dmiss = 1; dmiss_addr = 32'h2000_0044; imiss = 1; imiss_addr = 32'h0000_1238; mem_ack = 1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("both_d_sel", 32'(refill_sel), 32'd1);
      check("both_d_addr", mem_addr, 32'h2000_0040 + 32'(4 * k));
    end
    tick(); #1;
    check("both_d_done", 32'(refill_done), 32'd1);
    check("both_gap1", 32'(hit), 32'd0);
    tick(); #1;
    check("both_gap2", 32'(hit), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("both_i_sel", 32'(refill_sel), 32'd0);
      check("both_i_addr", mem_addr, 32'h0000_1230 + 32'(4 * k));
      check("both_i_hit", 32'(hit), 32'd0);
    end
    tick(); #1;
    check("both_i_done", 32'(refill_done), 32'd1);
    mem_ack = 0;
    tick(); #1;
    check("both_hit_back", 32'(hit), 32'd1);

    // ack withheld mid-FILL
    tick();
    imiss = 1; imiss_addr = 32'h0040_0104; mem_ack = 1;
    tick();
    tick();
    mem_ack = 0;
    for (int j = 0; j < 10; j++) begin
      #1;
      check("stall_addr", mem_addr, 32'h0040_0104);
      check("stall_idx", 32'(word_idx), 32'd1);
      check("stall_req", 32'(mem_req), 32'd1);
      check("stall_valid", 32'(refill_valid), 32'd0);
      tick();
    end
    mem_ack = 1;
    tick();
    tick();
    tick(); #1;
    check("stall_done", 32'(refill_done), 32'd1);
    mem_ack = 0;
    tick();

    // asynchronous reset at beat 2 of FILL
    tick();
    imiss = 1; imiss_addr = 32'h0080_0000; mem_ack = 1;
    tick();
    tick();
    tick();
    #1 check("ar_beat2", 32'(word_idx), 32'd2);
    #1 rst_n = 0;
    #1;
    check("ar_req", 32'(mem_req), 32'd0);
    check("ar_hit", 32'(hit), 32'd0);
    check("ar_valid", 32'(refill_valid), 32'd0);
    imiss = 0; mem_ack = 0;
    tick();
    tick();
    rst_n = 1;
    tick(); #1;
    check("ar_hit_after", 32'(hit), 32'd1);
    check("ar_idx_after", 32'(word_idx), 32'd0);
    check("ar_req_after", 32'(mem_req), 32'd0);

    // randomized traffic
    run_random(3000);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
